line_job_scheduler: RTL and testbench

//  Arbitrates line-draw jobs from NREQ requesters (animators, overlays) onto the single line_drawer.

---
 rtl/line_job_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_line_job_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_job_scheduler.sv
// Round-robin scheduler that feeds line-draw jobs to one line_drawer and muxes its pixels onto the framebuffer.
// Optional full-screen clear sweep is enabled by defining CLEAR_SCREEN_EN.
module line_job_scheduler #(
  parameter int NREQ    = 2,
  parameter int XW      = 10,
  parameter int YW      = 9,
  parameter int XMAX    = 639,
  parameter int YMAX    = 479,
  parameter int TIMEOUT = 4095
) (
  input  logic                 clk,
  input  logic                 reset_n,
`ifdef CLEAR_SCREEN_EN
  input  logic                 clear_req,
`endif
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*XW-1:0]   req_x0,
  input  logic [NREQ*XW-1:0]   req_x1,
  input  logic [NREQ*YW-1:0]   req_y0,
  input  logic [NREQ*YW-1:0]   req_y1,
  input  logic [NREQ-1:0]      req_color,
  output logic                 ld_start,
  output logic [XW-1:0]        ld_x0,
  output logic [XW-1:0]        ld_x1,
  output logic [YW-1:0]        ld_y0,
  output logic [YW-1:0]        ld_y1,
  input  logic [XW-1:0]        ld_x,
  input  logic [YW-1:0]        ld_y,
  input  logic                 ld_done,
  output logic [XW-1:0]        fb_x,
  output logic [YW-1:0]        fb_y,
  output logic                 fb_color,
  output logic                 fb_write,
  output logic                 busy,
  output logic                 abort_err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_START, S_DRAW, S_CLEAR} state_t;

  state_t          state;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   win;
  logic [PW-1:0]   idx;
  logic            win_vld;
  logic [TW-1:0]   timer;
  logic            job_color;

  logic [XW-1:0]   x0_a [NREQ];
  logic [XW-1:0]   x1_a [NREQ];
  logic [YW-1:0]   y0_a [NREQ];
  logic [YW-1:0]   y1_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign x0_a[g] = req_x0[g*XW +: XW];
    assign x1_a[g] = req_x1[g*XW +: XW];
    assign y0_a[g] = req_y0[g*YW +: YW];
    assign y1_a[g] = req_y1[g*YW +: YW];
  end

`ifdef CLEAR_SCREEN_EN
  logic [XW-1:0]   clr_x;
  logic [YW-1:0]   clr_y;
`endif

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(rr_ptr) + i) % NREQ);
      if (req_valid[idx]) begin
        win     = idx;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_GRANT && win_vld) req_ready[win] = 1'b1;
  end

  // Pixel mux is combinational from the registered state so the last drawer pixel lands with ld_done.
  always_comb begin
    fb_x     = '0;
    fb_y     = '0;
    fb_color = 1'b0;
    fb_write = 1'b0;
    if (state == S_DRAW) begin
      fb_x     = ld_x;
      fb_y     = ld_y;
      fb_color = job_color;
      fb_write = 1'b1;
    end
`ifdef CLEAR_SCREEN_EN
    else if (state == S_CLEAR) begin
      fb_x     = clr_x;
      fb_y     = clr_y;
      fb_write = 1'b1;
    end
`endif
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      ld_start  <= 1'b0;
      ld_x0     <= '0;
      ld_x1     <= '0;
      ld_y0     <= '0;
      ld_y1     <= '0;
      job_color <= 1'b0;
      timer     <= '0;
      abort_err <= 1'b0;
`ifdef CLEAR_SCREEN_EN
      clr_x     <= '0;
      clr_y     <= '0;
`endif
    end else begin
      ld_start <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef CLEAR_SCREEN_EN
          if (clear_req) begin
            clr_x <= '0;
            clr_y <= '0;
            state <= S_CLEAR;
          end else
`endif
          if (|req_valid) state <= S_GRANT;
        end
        S_GRANT: begin
          if (win_vld) begin
            ld_x0     <= x0_a[win];
            ld_x1     <= x1_a[win];
            ld_y0     <= y0_a[win];
            ld_y1     <= y1_a[win];
            job_color <= req_color[win];
            rr_ptr    <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
            ld_start  <= 1'b1;
            state     <= S_START;
          end else begin
            state <= S_IDLE;
          end
        end
        S_START: begin
          timer <= '0;
          state <= S_DRAW;
        end
        S_DRAW: begin
          timer <= timer + 1'b1;
          if (ld_done) begin
            state <= S_IDLE;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            abort_err <= 1'b1;
            state     <= S_IDLE;
          end
        end
`ifdef CLEAR_SCREEN_EN
        S_CLEAR: begin
          if (clr_x == XW'(XMAX)) begin
            clr_x <= '0;
            if (clr_y == YW'(YMAX)) state <= S_IDLE;
            else                    clr_y <= clr_y + 1'b1;
          end else begin
            clr_x <= clr_x + 1'b1;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_job_scheduler.sv
// Bench for line_job_scheduler: directed table, hand-written corner sequences, then randomized traffic
// checked by a transaction-level round-robin scoreboard.
module tb_line_job_scheduler;
  localparam int NREQ = 2, XW = 10, YW = 9, XMAX = 3, YMAX = 1, TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*XW-1:0] req_x0 = '0, req_x1 = '0;
  logic [NREQ*YW-1:0] req_y0 = '0, req_y1 = '0;
  logic [NREQ-1:0]    req_color = '0;
  logic               ld_start;
  logic [XW-1:0]      ld_x0, ld_x1;
  logic [YW-1:0]      ld_y0, ld_y1;
  logic [XW-1:0]      ld_x = '0;
  logic [YW-1:0]      ld_y = '0;
  logic               ld_done = 1'b0;
  logic [XW-1:0]      fb_x;
  logic [YW-1:0]      fb_y;
  logic               fb_color, fb_write, busy, abort_err;
`ifdef CLEAR_SCREEN_EN
  logic               clear_req = 1'b0;
`endif

  always #5 clk = ~clk;

  line_job_scheduler #(.NREQ(NREQ), .XW(XW), .YW(YW), .XMAX(XMAX), .YMAX(YMAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef CLEAR_SCREEN_EN
    .clear_req(clear_req),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_x1(req_x1), .req_y0(req_y0), .req_y1(req_y1), .req_color(req_color),
    .ld_start(ld_start), .ld_x0(ld_x0), .ld_x1(ld_x1), .ld_y0(ld_y0), .ld_y1(ld_y1),
    .ld_x(ld_x), .ld_y(ld_y), .ld_done(ld_done),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .busy(busy), .abort_err(abort_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic ceq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input int x0, input int y0, input int x1, input int y1, input int c);
    req_x0[i*XW +: XW] = XW'(x0);
    req_y0[i*YW +: YW] = YW'(y0);
    req_x1[i*XW +: XW] = XW'(x1);
    req_y1[i*YW +: YW] = YW'(y1);
    req_color[i]       = c[0];
  endtask

  task automatic rand_req(input int i);
    set_req(i, $urandom_range(0, 1023), $urandom_range(0, 511),
            $urandom_range(0, 1023), $urandom_range(0, 511), $urandom_range(0, 1));
  endtask

  task automatic wait_grant(output logic [NREQ-1:0] got, output int cyc);
    got = '0;
    cyc = 0;
    while (got == '0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = req_ready;
    end
    if (got == '0) ceq("grant_timeout", 0, 1);
  endtask

  // Called right after the GRANT-cycle sample; plays the drawer for L pixels.
  task automatic run_draw(input int L, input logic col, input bit drop);
    @(negedge clk);
    ceq("drw_start", ld_start, 1);
    if (drop) req_valid = '0;
    ld_done = 1'b0;
    ld_x = XW'($urandom_range(0, 1023));
    ld_y = YW'($urandom_range(0, 511));
    for (int k = 1; k <= L; k++) begin
      @(negedge clk);
      ceq("drw_fb_write", fb_write, 1);
      ceq("drw_fb_x", fb_x, ld_x);
      ceq("drw_fb_y", fb_y, ld_y);
      ceq("drw_fb_color", fb_color, col);
      ld_x = XW'($urandom_range(0, 1023));
      ld_y = YW'($urandom_range(0, 511));
      ld_done = (k == L);
    end
    @(posedge clk);
    #1 ld_done = 1'b0;
  endtask

  typedef struct {
    logic [1:0] valid;
    int         slot;
    int         x0, y0, x1, y1;
    logic       col;
    logic [1:0] ready;
  } vec_t;

  vec_t tbl[6];

  logic [NREQ-1:0] got;
  int cyc, n;
  int rr_exp, w, hs, cnt, L, grants, idle_wait;
  bit drawing;
  logic [XW-1:0] jx0, jx1;
  logic [YW-1:0] jy0, jy1;
  logic jc;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{valid: 2'b01, slot: 0, x0: 10,   y0: 20,  x1: 50,  y1: 60,  col: 1'b1, ready: 2'b01};
    tbl[1] = '{valid: 2'b11, slot: 1, x0: 0,    y0: 0,   x1: 639, y1: 479, col: 1'b0, ready: 2'b10};
    tbl[2] = '{valid: 2'b11, slot: 0, x0: 5,    y0: 5,   x1: 5,   y1: 5,   col: 1'b1, ready: 2'b01};
    tbl[3] = '{valid: 2'b01, slot: 0, x0: 639,  y0: 479, x1: 0,   y1: 0,   col: 1'b1, ready: 2'b01};
    tbl[4] = '{valid: 2'b10, slot: 1, x0: 1023, y0: 511, x1: 1,   y1: 2,   col: 1'b0, ready: 2'b10};
    tbl[5] = '{valid: 2'b10, slot: 1, x0: 300,  y0: 7,   x1: 8,   y1: 400, col: 1'b1, ready: 2'b10};

    // Reset with both requesters pending, then round-robin with 5-pixel jobs.
    set_req(0, 1, 1, 2, 2, 1);
    set_req(1, 3, 3, 4, 4, 0);
    req_valid = 2'b11;
    repeat (3) @(negedge clk);
    ceq("rst_req_ready", req_ready, 0);
    ceq("rst_ld_start", ld_start, 0);
    ceq("rst_fb_write", fb_write, 0);
    ceq("rst_fb_xy", {fb_x, fb_y, fb_color}, 0);
    ceq("rst_busy", busy, 0);
    ceq("rst_abort", abort_err, 0);
    ceq("rst_ld_xy", {ld_x0, ld_y0, ld_x1, ld_y1}, 0);
    reset_n = 1'b1;
    wait_grant(got, cyc);
    ceq("rst_first_ready", got, 2'b01);
    ceq("rst_ready_latency", cyc, 1);
    run_draw(5, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) begin
      wait_grant(got, cyc);
      ceq("rr_grant", got, (j % 2 == 0) ? 2'b10 : 2'b01);
      ceq("rr_gap", cyc, 2);
      run_draw(5, (j % 2 == 0) ? 1'b0 : 1'b1, 1'b0);
    end
    req_valid = '0;

    // Table of single jobs with a fixed 2-pixel draw.
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      ceq("tbl_idle", busy, 0);
      set_req(tbl[t].slot, tbl[t].x0, tbl[t].y0, tbl[t].x1, tbl[t].y1, tbl[t].col);
      set_req(1 - tbl[t].slot, 77, 66, 55, 44, ~tbl[t].col);
      req_valid = tbl[t].valid;
      @(negedge clk);
      ceq("tbl_ready", req_ready, tbl[t].ready);
      ceq("tbl_busy", busy, 1);
      @(negedge clk);
      req_valid = '0;
      ceq("tbl_start", ld_start, 1);
      ceq("tbl_ld_x0", ld_x0, tbl[t].x0);
      ceq("tbl_ld_y0", ld_y0, tbl[t].y0);
      ceq("tbl_ld_x1", ld_x1, tbl[t].x1);
      ceq("tbl_ld_y1", ld_y1, tbl[t].y1);
      ld_x = XW'($urandom_range(0, 1023));
      ld_y = YW'($urandom_range(0, 511));
      ld_done = 1'b0;
      @(negedge clk);
      ceq("tbl_fb_write", fb_write, 1);
      ceq("tbl_fb_x", fb_x, ld_x);
      ceq("tbl_fb_y", fb_y, ld_y);
      ceq("tbl_fb_color", fb_color, tbl[t].col);
      ceq("tbl_hold_x0", ld_x0, tbl[t].x0);
      ceq("tbl_hold_y1", ld_y1, tbl[t].y1);
      ceq("tbl_no_restart", ld_start, 0);
      ld_x = XW'($urandom_range(0, 1023));
      @(negedge clk);
      ceq("tbl_fb_write2", fb_write, 1);
      ceq("tbl_fb_x2", fb_x, ld_x);
      ld_done = 1'b1;
      @(negedge clk);
      ceq("tbl_end_write", fb_write, 0);
      ceq("tbl_end_fb", {fb_x, fb_y, fb_color}, 0);
      ceq("tbl_end_busy", busy, 0);
      ld_done = 1'b0;
    end

    // Winner's valid drops during GRANT: no ready pulse, back to IDLE.
    @(negedge clk);
    set_req(0, 9, 9, 9, 9, 1);
    req_valid = 2'b01;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    ceq("drop_ready", req_ready, 0);
    ceq("drop_busy_grant", busy, 1);
    @(negedge clk);
    ceq("drop_busy", busy, 0);
    ceq("drop_no_start", ld_start, 0);

    // Timeout: the drawer never finishes.
    @(negedge clk);
    set_req(1, 100, 100, 200, 200, 1);
    req_valid = 2'b10;
    wait_grant(got, cyc);
    ceq("to_grant", got, 2'b10);
    @(negedge clk);
    req_valid = '0;
    ceq("to_start", ld_start, 1);
    ceq("to_abort_pre", abort_err, 0);
    n = 0;
    @(negedge clk);
    while (fb_write && n < 100) begin
      n++;
      @(negedge clk);
    end
    ceq("to_draw_cycles", n, TIMEOUT);
    ceq("to_abort", abort_err, 1);
    ceq("to_busy", busy, 0);
    set_req(0, 1, 2, 3, 4, 0);
    req_valid = 2'b01;
    wait_grant(got, cyc);
    ceq("to_next_grant", got, 2'b01);
    run_draw(3, 1'b0, 1'b1);
    @(negedge clk);
    ceq("to_sticky", abort_err, 1);

    // Reset in the middle of a draw.
    set_req(1, 7, 8, 9, 10, 1);
    req_valid = 2'b10;
    wait_grant(got, cyc);
    ceq("mr_grant", got, 2'b10);
    @(negedge clk);
    req_valid = '0;
    ceq("mr_start", ld_start, 1);
    @(negedge clk);
    ceq("mr_fbw_pre", fb_write, 1);
    #1 reset_n = 1'b0;
    #1;
    ceq("mr_fbw_async", fb_write, 0);
    ceq("mr_busy_async", busy, 0);
    ceq("mr_abort_clr", abort_err, 0);
    ceq("mr_job_clr", ld_x0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    ceq("mr_idle", busy, 0);
    ceq("mr_fbw_after", fb_write, 0);

`ifdef CLEAR_SCREEN_EN
    // Clear sweep has priority over a pending job.
    set_req(0, 1, 2, 3, 4, 1);
    req_valid = 2'b01;
    clear_req = 1'b1;
    @(negedge clk);
    clear_req = 1'b0;
    for (int k = 0; k < (XMAX + 1) * (YMAX + 1); k++) begin
      if (k > 0) @(negedge clk);
      ceq("clr_write", fb_write, 1);
      ceq("clr_x", fb_x, k % (XMAX + 1));
      ceq("clr_y", fb_y, k / (XMAX + 1));
      ceq("clr_color", fb_color, 0);
      ceq("clr_no_ready", req_ready, 0);
      ceq("clr_busy", busy, 1);
    end
    wait_grant(got, cyc);
    ceq("clr_then_grant", got, 2'b01);
    ceq("clr_grant_gap", cyc, 2);
    run_draw(1, 1'b1, 1'b1);
`endif

    // Randomized traffic against a round-robin scoreboard.
    @(negedge clk);
    reset_n = 1'b0;
    req_valid = '0;
    ld_done = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    rr_exp = 0; hs = -1; cnt = 0; L = 1; grants = 0; idle_wait = 0; drawing = 1'b0;
    jx0 = '0; jx1 = '0; jy0 = '0; jy1 = '0; jc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++)
          if (w < 0 && req_valid[(rr_exp + k) % NREQ]) w = (rr_exp + k) % NREQ;
        ceq("rnd_ready", req_ready, (w < 0) ? 0 : (1 << w));
        ceq("rnd_no_preempt", drawing, 0);
        if (w >= 0) begin
          rr_exp = (w + 1) % NREQ;
          jx0 = req_x0[w*XW +: XW]; jx1 = req_x1[w*XW +: XW];
          jy0 = req_y0[w*YW +: YW]; jy1 = req_y1[w*YW +: YW];
          jc  = req_color[w];
          hs  = w;
          grants++;
        end
      end
      if (ld_start) begin
        ceq("rnd_ld_x0", ld_x0, jx0);
        ceq("rnd_ld_y0", ld_y0, jy0);
        ceq("rnd_ld_x1", ld_x1, jx1);
        ceq("rnd_ld_y1", ld_y1, jy1);
        drawing = 1'b1;
        cnt = 0;
        L = $urandom_range(1, 8);
        ld_done = 1'b0;
      end else if (fb_write) begin
        if (!drawing) ceq("rnd_stray_write", fb_write, 0);
        else begin
          if (fb_x != ld_x || fb_y != ld_y || fb_color != jc)
            ceq("rnd_fb_pixel", {fb_x, fb_y, fb_color}, {ld_x, ld_y, jc});
          cnt++;
          ld_done = (cnt == L);
          if (cnt == L) drawing = 1'b0;
        end
      end else begin
        if (drawing) begin
          ceq("rnd_draw_gap", fb_write, 1);
          drawing = 1'b0;
        end
        ld_done = 1'b0;
      end
      if (|req_valid && !drawing && req_ready == '0 && !ld_start) idle_wait++;
      else idle_wait = 0;
      if (idle_wait > 2) begin
        ceq("rnd_stall", idle_wait, 2);
        idle_wait = 0;
      end
      ld_x = XW'($urandom_range(0, 1023));
      ld_y = YW'($urandom_range(0, 511));
      if (req_ready == '0) begin
        if (hs >= 0) begin
          req_valid[hs] = (c < 2960) && ($urandom_range(0, 3) != 0);
          if (req_valid[hs]) rand_req(hs);
          hs = -1;
        end
        for (int i = 0; i < NREQ; i++)
          if (!req_valid[i] && c < 2960 && $urandom_range(0, 3) == 0) begin
            rand_req(i);
            req_valid[i] = 1'b1;
          end
      end
    end
    ceq("rnd_progress", (grants >= 100) ? 1 : 0, 1);
    ceq("rnd_end_drawing", drawing, 0);
    ceq("rnd_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
